// File: rtl/note_player_if.sv
// note_player_if
//   Groups every non-clock/reset signal of the note player:
//     - timing strobe        : i_tick
//     - sequencer handshake  : o_note_stb, i_note_valid, i_note_pitch,
//                              i_note_len, i_note_instrument
//     - pitch-table ROM port : o_pitch_rom_addr, i_pitch_rom_data
//     - voice control        : o_voice_step, o_voice_instrument,
//                              o_voice_gate, o_voice_retrigger
//   Signal names keep the player's point of view (i_ = into the player).
//   master : the note player itself
//   slave  : the surrounding system (sequencer, ROM, voice, tick source)
interface note_player_if;
    logic        i_tick;
    logic        o_note_stb;
    logic        i_note_valid;
    logic [5:0]  i_note_pitch;
    logic [4:0]  i_note_len;
    logic [3:0]  i_note_instrument;
    logic [5:0]  o_pitch_rom_addr;
    logic [15:0] i_pitch_rom_data;
    logic [15:0] o_voice_step;
    logic [3:0]  o_voice_instrument;
    logic        o_voice_gate;
    logic        o_voice_retrigger;

    modport master (
        input  i_tick, i_note_valid, i_note_pitch, i_note_len,
               i_note_instrument, i_pitch_rom_data,
        output o_note_stb, o_pitch_rom_addr, o_voice_step,
               o_voice_instrument, o_voice_gate, o_voice_retrigger
    );

    modport slave (
        output i_tick, i_note_valid, i_note_pitch, i_note_len,
               i_note_instrument, i_pitch_rom_data,
        input  o_note_stb, o_pitch_rom_addr, o_voice_step,
               o_voice_instrument, o_voice_gate, o_voice_retrigger
    );
endinterface

// File: rtl/note_player.sv
// note_player
//   Fetches notes from a pattern sequencer, looks up the oscillator phase
//   step in a synchronous pitch ROM and plays each note for
//   len * TICKS_PER_UNIT frame ticks, with the gate dropped for the last
//   GAP_TICKS ticks so consecutive notes are articulated.
// Ports
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : note_player_if.master (tick, sequencer handshake, ROM, voice)
module note_player #(
    parameter int TICKS_PER_UNIT = 4,
    parameter int GAP_TICKS      = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    note_player_if.master  bus
);
    localparam logic [15:0] TPU16 = 16'(TICKS_PER_UNIT);
    localparam logic [15:0] GAP16 = 16'(GAP_TICKS);

    typedef enum logic [2:0] {
        IDLE, REQUEST, WAIT_NOTE, ROM_ADDR, ROM_DATA, PLAY
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  pitch_reg;
    logic [4:0]  len_reg;
    logic [3:0]  instr_reg;
    logic [15:0] remaining_reg, remaining_next;
    logic        tick_pending_reg, tick_pending_next;
    logic [15:0] step_reg;
    logic [3:0]  voice_instr_reg;
    logic        gate_reg;
    logic        retrig_reg;
    logic        latch_note;
    logic        note_stb;
    logic        play_tick;
    logic [5:0]  units;
    logic [15:0] load_value;

    // A length of 0 encodes the longest note, 32 units.
    assign units      = (len_reg == 5'd0) ? 6'd32 : {1'b0, len_reg};
    assign load_value = 16'(units) * TPU16;

    always_comb begin
        state_next        = state_reg;
        remaining_next    = remaining_reg;
        tick_pending_next = tick_pending_reg;
        latch_note        = 1'b0;
        note_stb          = 1'b0;
        play_tick         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_tick) state_next = REQUEST;
            end
            REQUEST: begin
                note_stb   = 1'b1;
                state_next = WAIT_NOTE;
                if (bus.i_tick) tick_pending_next = 1'b1;
            end
            WAIT_NOTE: begin
                if (bus.i_tick) tick_pending_next = 1'b1;
                if (bus.i_note_valid) begin
                    latch_note = 1'b1;
                    state_next = ROM_ADDR;
                end
            end
            ROM_ADDR: begin
                if (bus.i_tick) tick_pending_next = 1'b1;
                state_next = ROM_DATA;
            end
            ROM_DATA: begin
                if (bus.i_tick) tick_pending_next = 1'b1;
                remaining_next = load_value;
                state_next     = PLAY;
            end
            PLAY: begin
                // A tick held over from the fetch phase is counted in the
                // first PLAY cycle; only one decrement happens per cycle.
                play_tick         = bus.i_tick | tick_pending_reg;
                tick_pending_next = 1'b0;
                if (play_tick) begin
                    if (remaining_reg == 16'd1) begin
                        remaining_next = 16'd0;
                        state_next     = REQUEST;
                    end else begin
                        remaining_next = remaining_reg - 16'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg        <= IDLE;
            remaining_reg    <= 16'd0;
            tick_pending_reg <= 1'b0;
            pitch_reg        <= 6'd0;
            len_reg          <= 5'd0;
            instr_reg        <= 4'd0;
            step_reg         <= 16'd0;
            voice_instr_reg  <= 4'd0;
            gate_reg         <= 1'b0;
            retrig_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            remaining_reg    <= remaining_next;
            tick_pending_reg <= tick_pending_next;
            if (latch_note) begin
                pitch_reg <= bus.i_note_pitch;
                len_reg   <= bus.i_note_len;
                instr_reg <= bus.i_note_instrument;
            end
            // ROM data for the address presented in ROM_ADDR is valid now.
            if (state_reg == ROM_DATA) begin
                step_reg        <= (pitch_reg == 6'd0) ? 16'd0 : bus.i_pitch_rom_data;
                voice_instr_reg <= instr_reg;
            end
            retrig_reg <= (state_reg == ROM_DATA) && (pitch_reg != 6'd0);
            // Gate is computed from the next counter value so the registered
            // gate always agrees with the registered counter.
            gate_reg <= (state_next == PLAY) && (pitch_reg != 6'd0)
                        && (remaining_next > GAP16);
        end
    end

    assign bus.o_note_stb         = note_stb;
    assign bus.o_pitch_rom_addr   = pitch_reg;
    assign bus.o_voice_step       = step_reg;
    assign bus.o_voice_instrument = voice_instr_reg;
    assign bus.o_voice_gate       = gate_reg;
    assign bus.o_voice_retrigger  = retrig_reg;
endmodule

// File: tb/tb_note_player.sv
// tb_note_player
//   Directed bench for note_player with TICKS_PER_UNIT=4, GAP_TICKS=1.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_note_player;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    note_player_if bus();

    note_player #(.TICKS_PER_UNIT(4), .GAP_TICKS(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pitch ROM, one cycle of latency.
    function automatic logic [15:0] rom_value(input logic [5:0] a);
        if (a == 6'd10) return 16'h1234;
        return 16'hA000 | {10'd0, a};
    endfunction

    always @(posedge clk) bus.i_pitch_rom_data <= rom_value(bus.o_pitch_rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle, then one tick cycle; samples right after the tick edge.
    task automatic do_tick();
        step();
        bus.i_tick = 1'b1;
        step();
        bus.i_tick = 1'b0;
    endtask

    // Presents a note for one cycle (from WAIT_NOTE) and walks to the first
    // PLAY cycle. When with_tick is set a tick coincides with i_note_valid.
    task automatic load_note(input logic [5:0] p, input logic [4:0] l,
                             input logic [3:0] ins, input bit with_tick);
        bus.i_note_valid      = 1'b1;
        bus.i_note_pitch      = p;
        bus.i_note_len        = l;
        bus.i_note_instrument = ins;
        bus.i_tick            = with_tick;
        step();                                  // now ROM_ADDR
        bus.i_note_valid = 1'b0;
        bus.i_tick       = 1'b0;
        check("rom_addr", bus.o_pitch_rom_addr, p);
        check("gate_fetch", bus.o_voice_gate, 0);
        step();                                  // ROM_DATA
        step();                                  // first PLAY cycle
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stb"},   bus.o_note_stb, 0);
        check({tag, "_gate"},  bus.o_voice_gate, 0);
        check({tag, "_retrig"}, bus.o_voice_retrigger, 0);
        check({tag, "_step"},  bus.o_voice_step, 0);
        check({tag, "_instr"}, bus.o_voice_instrument, 0);
        check({tag, "_addr"},  bus.o_pitch_rom_addr, 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.i_tick = 1'b0;
        bus.i_note_valid = 1'b0;
        bus.i_note_pitch = 6'd0;
        bus.i_note_len = 5'd0;
        bus.i_note_instrument = 4'd0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Idle without ticks: no strobe.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_stb", bus.o_note_stb, 0);
        end
        bus.i_tick = 1'b1;
        step();
        bus.i_tick = 1'b0;
        check("first_stb", bus.o_note_stb, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_more_stb", bus.o_note_stb, 0);
        end

        // Note: pitch 10, len 2, instrument 3 -> 8 ticks.
        load_note(6'd10, 5'd2, 4'd3, 1'b0);
        check("n1_step", bus.o_voice_step, 16'h1234);
        check("n1_instr", bus.o_voice_instrument, 3);
        check("n1_retrig", bus.o_voice_retrigger, 1);
        check("n1_gate0", bus.o_voice_gate, 1);
        step();
        check("n1_retrig_end", bus.o_voice_retrigger, 0);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            check("n1_gate", bus.o_voice_gate, (k < 7) ? 1 : 0);
            check("n1_stb", bus.o_note_stb, (k == 8) ? 1 : 0);
        end
        step();
        check("n1_step_hold", bus.o_voice_step, 16'h1234);
        check("n1_stb_once", bus.o_note_stb, 0);

        // Rest note: pitch 0, len 1 -> 4 ticks, silent.
        load_note(6'd0, 5'd1, 4'd5, 1'b0);
        check("rest_step", bus.o_voice_step, 0);
        check("rest_instr", bus.o_voice_instrument, 5);
        check("rest_retrig", bus.o_voice_retrigger, 0);
        check("rest_gate0", bus.o_voice_gate, 0);
        for (int k = 1; k <= 4; k++) begin
            do_tick();
            check("rest_gate", bus.o_voice_gate, 0);
            check("rest_stb", bus.o_note_stb, (k == 4) ? 1 : 0);
        end
        step();

        // len 0 -> 128 ticks; gate falls after tick 127.
        load_note(6'd7, 5'd0, 4'd1, 1'b0);
        check("long_step", bus.o_voice_step, 16'hA007);
        check("long_retrig", bus.o_voice_retrigger, 1);
        for (int k = 1; k <= 128; k++) begin
            do_tick();
            check("long_gate", bus.o_voice_gate, (k < 127) ? 1 : 0);
            check("long_stb", bus.o_note_stb, (k == 128) ? 1 : 0);
        end
        step();

        // Two ticks while waiting: only one is kept and counted on entry.
        do_tick();
        do_tick();
        step();
        load_note(6'd3, 5'd1, 4'd2, 1'b0);
        check("pend_retrig", bus.o_voice_retrigger, 1);
        check("pend_gate0", bus.o_voice_gate, 1);
        step();
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            check("pend_gate", bus.o_voice_gate, (k < 2) ? 1 : 0);
            check("pend_stb", bus.o_note_stb, (k == 3) ? 1 : 0);
        end
        step();

        // Tick coincident with i_note_valid is held as pending.
        load_note(6'd10, 5'd1, 4'd4, 1'b1);
        check("coin_instr", bus.o_voice_instrument, 4);
        step();
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            check("coin_stb", bus.o_note_stb, (k == 3) ? 1 : 0);
        end
        step();

        // Reset in the middle of a sounding note.
        load_note(6'd10, 5'd2, 4'd6, 1'b0);
        do_tick();
        do_tick();
        check("mid_gate", bus.o_voice_gate, 1);
        rst = 1'b1;
        bus.i_tick = 1'b1;
        step();
        bus.i_tick = 1'b0;
        check_all_zero("midrst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_stb", bus.o_note_stb, 0);
        end
        bus.i_tick = 1'b1;
        step();
        bus.i_tick = 1'b0;
        check("post_rst_first_stb", bus.o_note_stb, 1);
        check("post_rst_gate", bus.o_voice_gate, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
